// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode map, widths, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int SEL_W       = 16;
    localparam int OPC_W       = 4;
    localparam int DATA_W      = 8;
    localparam int NUM_OPS_DEF = 9;

    // Opcode map; the one-hot selector bit index equals the opcode value.
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPC_W-1:0] OP_NOTA = 4'd2;
    localparam logic [OPC_W-1:0] OP_NAND = 4'd3;
    localparam logic [OPC_W-1:0] OP_NOR  = 4'd4;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd5;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd7;
    localparam logic [OPC_W-1:0] OP_XNOR = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Opcode to one-hot ALU selector plus legality flag.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module opcode_decoder
    import alu_pkg::*;
#(
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [SEL_W-1:0] sel,
    output logic             legal
);

    // One extra bit so NUM_OPS = 16 (every opcode legal) still fits.
    localparam logic [OPC_W:0] OP_LIMIT = 5'(NUM_OPS);

    // Legal opcodes light exactly one selector bit; illegal ones leave it all-zero.
    always_comb begin
        legal = ({1'b0, opcode} < OP_LIMIT);
        sel   = '0;
        if (legal) begin
            sel[opcode] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/sequence stage: registers one op, drives ALU one-hot selector for one cycle, pulses done.
// Latency: accept edge T -> selector during T+2 -> done during T+3 -> ready again during T+4.
// Backpressure: in_ready only in IDLE; requests outside IDLE are ignored, no buffering.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  b,
    output logic [SEL_W-1:0]   selector,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [COUNT_W-1:0] op_count
);

    state_t              state_q,   state_d;
    logic [DATA_W-1:0]   a_q,       a_d;
    logic [DATA_W-1:0]   b_q,       b_d;
    logic [OPC_W-1:0]    opc_q,     opc_d;
    logic [SEL_W-1:0]    sel_q,     sel_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                illegal_q, illegal_d;
    logic [COUNT_W-1:0]  cnt_q,     cnt_d;

    logic [SEL_W-1:0]    dec_sel;
    logic                dec_legal;

    // Decode works on the captured opcode so the selector is ready one cycle after accept.
    opcode_decoder #(
        .NUM_OPS (NUM_OPS)
    ) u_dec (
        .opcode (opc_q),
        .sel    (dec_sel),
        .legal  (dec_legal)
    );

    // Next-state and registered-output logic; pulses are computed one state early so
    // they land in the state they belong to.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        opc_d     = opc_q;
        cnt_d     = cnt_q;
        sel_d     = '0;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    opc_d   = in_opcode;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    sel_d   = dec_sel;
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_ERROR;
                end
            end
            ST_EXECUTE: begin
                // ALU samples the selector at the end of this cycle; its result is
                // valid next cycle, which is when done is shown.
                done_d  = 1'b1;
                cnt_d   = cnt_q + COUNT_W'(1);
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset; reset drops any in-flight pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            opc_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opc_q     <= opc_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign a        = a_q;
    assign b        = b_q;
    assign selector = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] selector;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [7:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .NUM_OPS (9),
        .COUNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .a         (a),
        .b         (b),
        .selector  (selector),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .op_count  (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Checks every cycle of one legal op.
    task automatic run_legal(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                             input logic [7:0] exp_cnt, input bit hold, input bit pulse);
        logic [15:0] exp_sel;
        exp_sel   = 16'h0001 << op;
        in_opcode = op;
        in_a      = va;
        in_b      = vb;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        @(negedge clk);
        check("decode_sel",   32'(selector), 32'h0);
        check("decode_busy",  32'(busy), 32'h1);
        check("decode_ready", 32'(in_ready), 32'h0);
        if (pulse) begin
            in_valid  = 1'b1;
            in_opcode = 4'd2;
            in_a      = 8'hFF;
            in_b      = 8'hEE;
        end
        @(negedge clk);
        check("exec_sel",  32'(selector), 32'(exp_sel));
        check("exec_a",    32'(a), 32'(va));
        check("exec_b",    32'(b), 32'(vb));
        check("exec_done", 32'(done), 32'h0);
        @(negedge clk);
        check("result_done",    32'(done), 32'h1);
        check("result_sel",     32'(selector), 32'h0);
        check("result_illegal", 32'(illegal), 32'h0);
        check("result_count",   32'(op_count), 32'(exp_cnt));
        check("result_a",       32'(a), 32'(va));
        if (pulse) in_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'h1);
        check("idle_busy",  32'(busy), 32'h0);
        check("idle_done",  32'(done), 32'h0);
    endtask

    // Called at a negedge with the DUT idle. Checks the reject path of an illegal opcode.
    task automatic run_illegal(input logic [3:0] op, input logic [7:0] exp_cnt);
        in_opcode = op;
        in_a      = 8'h3C;
        in_b      = 8'hC3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_dec_sel", 32'(selector), 32'h0);
        check("ill_dec_ill", 32'(illegal), 32'h0);
        @(negedge clk);
        check("ill_pulse",   32'(illegal), 32'h1);
        check("ill_sel",     32'(selector), 32'h0);
        check("ill_done",    32'(done), 32'h0);
        check("ill_busy",    32'(busy), 32'h1);
        @(negedge clk);
        check("ill_ready",   32'(in_ready), 32'h1);
        check("ill_cleared", 32'(illegal), 32'h0);
        check("ill_done2",   32'(done), 32'h0);
        check("ill_sel2",    32'(selector), 32'h0);
        check("ill_count",   32'(op_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opcode = 4'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;

        // Reset values, with in_valid asserted alongside reset: nothing may be accepted.
        in_valid  = 1'b1;
        in_opcode = 4'd3;
        in_a      = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",   32'(in_ready), 32'h1);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_sel",     32'(selector), 32'h0);
        check("rst_a",       32'(a), 32'h0);
        check("rst_b",       32'(b), 32'h0);
        check("rst_done",    32'(done), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        check("rst_count",   32'(op_count), 32'h0);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'h0);

        // Add, then subtract with b > a.
        run_legal(4'd0, 8'h12, 8'h34, 8'd1, 1'b0, 1'b0);
        run_legal(4'd1, 8'h05, 8'h09, 8'd2, 1'b0, 1'b0);

        // Illegal opcodes: the first undefined one and one further up.
        run_illegal(4'd12, 8'd2);
        run_illegal(4'd9,  8'd2);
        run_illegal(4'd15, 8'd2);

        // Back-to-back sweep of every legal opcode with in_valid held high.
        do_reset();
        for (int op = 0; op < 9; op++) begin
            run_legal(4'(op), 8'(8'h10 + op), 8'(8'hA0 - op), 8'(op + 1), 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("sweep_count", 32'(op_count), 32'd9);

        // Reset asserted during EXECUTE.
        in_opcode = 4'd7;
        in_a      = 8'hAA;
        in_b      = 8'h55;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_exec_sel", 32'(selector), 32'h0080);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_sel",   32'(selector), 32'h0);
        check("midrst_a",     32'(a), 32'h0);
        check("midrst_b",     32'(b), 32'h0);
        check("midrst_done",  32'(done), 32'h0);
        check("midrst_count", 32'(op_count), 32'h0);
        check("midrst_ready", 32'(in_ready), 32'h1);
        check("midrst_busy",  32'(busy), 32'h0);
        @(negedge clk);
        check("midrst_done2", 32'(done), 32'h0);

        // Counter wrap: 255 completions, then one more op with in_valid pulsed while busy.
        for (int i = 0; i < 255; i++) begin
            in_opcode = 4'd5;
            in_a      = 8'(i);
            in_b      = 8'hF0;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("preload_count", 32'(op_count), 32'd255);
        run_legal(4'd6, 8'h0F, 8'h33, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("wrap_no_extra_done", 32'(done), 32'h0);
        check("wrap_no_extra_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        check("wrap_count_stable", 32'(op_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-and-sequence stage sitting directly upstream of the ALU in the simple processor. Accepts one operation at a time (4-bit opcode plus two 8-bit operands) over a valid/ready handshake, registers the operands, and converts the opcode to the ALU's 16-bit one-hot selector. Drives that selector for exactly one clock, then pulses `done` in the cycle the ALU's registered result, `left`/`right`/`negative`, is valid. Rejects undefined opcodes and counts completed operations.

## Interface
Parameters:
- `NUM_OPS`, default 9: number of legal opcodes, 0..NUM_OPS-1.
- `COUNT_W`, default 8: width of the completed-operation counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `in_valid`  in  1  operation request valid.
- `in_ready`  out  1  sequencer can accept; high only in IDLE.
- `in_opcode`  in  4  operation code.
- `in_a`  in  8  operand A.
- `in_b`  in  8  operand B.
- `a`  out  8  registered operand A to ALU.
- `b`  out  8  registered operand B to ALU.
- `selector`  out  16  one-hot ALU operation select; all-zero when not executing.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: ALU result valid this cycle.
- `illegal`  out  1  one-cycle pulse: accepted opcode was ≥ NUM_OPS.
- `op_count`  out  COUNT_W  number of legally completed operations, modulo 2^COUNT_W.

## Operation
- Opcode map, with selector bit = opcode: 0 add, 1 sub (abs diff), 2 not A, 3 nand, 4 nor, 5 and, 6 xor, 7 or, 8 xnor. Opcodes 9–15 are illegal.
- FSM states: IDLE, DECODE, EXECUTE, RESULT, ERROR.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `in_a`→`a`, `in_b`→`b`, `in_opcode`→internal opcode register; go to DECODE.
- DECODE: decode the opcode. Legal → EXECUTE. Illegal → ERROR.
- EXECUTE: `selector` = one-hot(opcode) for this cycle only; go to RESULT.
- RESULT:
  - `done`=1; `op_count` increments, wrapping from 2^COUNT_W−1 to 0.
  - Go to IDLE.
- ERROR: `illegal`=1; `selector` stays 0; `op_count` unchanged; go to IDLE.
- `a`/`b` hold their values until the next accept, so they are stable through EXECUTE.
- `selector` is 0 in every state except EXECUTE. The ALU retains its previous result while `selector` is 0.
- `in_valid` outside IDLE is ignored. No buffering; upstream holds the request until `in_ready`.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `a`=0, `b`=0, `selector`=0, `busy`=0, `done`=0, `illegal`=0, `op_count`=0, `in_ready`=1 (combinational from IDLE).
- Accept edge T:
  - DECODE during T+1.
  - `selector` valid during T+2; the ALU samples at the T+3 edge.
  - `done`=1 during T+3, coincident with valid ALU outputs.
  - IDLE during T+4.
- Throughput: one operation per 4 cycles. Back-to-back: `in_valid` held high → next accept at the edge ending T+4.
- Illegal path: accept T → `illegal` during T+2 → IDLE during T+3.
- `reset` in any state: next cycle IDLE with all reset values. An in-flight `done` or `illegal` is suppressed; `op_count` clears.
- `reset` and `in_valid` asserted together: reset wins, nothing is accepted.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_ADD..OP_XNOR), `NUM_OPS` default, FSM state typedef, `SEL_W`=16.
- Sub-module `opcode_decoder`: combinational, 4-bit opcode → 16-bit one-hot plus `legal` flag. Reused by the instruction decoder later.
- Top: FSM, operand/opcode registers, counter, handshake.

## Test plan
- Reset, then add: opcode 0, a=8'h12, b=8'h34 → `selector`=16'h0001 for exactly one cycle at T+2; `done` at T+3; ALU `left`/`right`=4'h4/4'h6; `op_count`=1.
- Sub with b>a: opcode 1, a=5, b=9 → `selector`=16'h0002; at `done`, `negative`=1 and result 8'h04.
- Full sweep: opcodes 0..8 back-to-back with `in_valid` held high → accepts every 4 cycles; each `selector` equals 1<<opcode; `op_count`=9.
- Illegal: opcode 12 → `illegal` pulse at T+2; `selector` never nonzero; no `done`; `op_count` unchanged; `in_ready` again at T+3.
- Reset mid-op: assert `reset` during EXECUTE → next cycle `selector`=0, `a`=`b`=0, no `done`, `op_count`=0, `in_ready`=1.
- Wrap: preload 255 completions (COUNT_W=8), then one more op → `op_count`=0; `in_valid` pulsed while busy → ignored, no extra completion.
